// File: rtl/debug_sequencer_if.sv
// Signal bundle between debug_sequencer and its UART / processor-core neighbours.
// The master modport is the sequencer side; slave is the environment side.
interface debug_sequencer_if #(
    parameter int UART_WIDTH     = 8,
    parameter int INST_WIDTH     = 32,
    parameter int IM_ADDR_LENGTH = 32,
    parameter int DM_ADDR_LENGTH = 32
) ();
    logic [UART_WIDTH-1:0]     rx_data;
    logic                      rx_done;
    logic                      tx_done;
    logic [UART_WIDTH-1:0]     tx_data;
    logic                      tx_start;
    logic                      halt_flag;
    logic [INST_WIDTH-1:0]     pc_value;
    logic [INST_WIDTH-1:0]     rf_data;
    logic [INST_WIDTH-1:0]     dm_data;
    logic [4:0]                rf_addr;
    logic [DM_ADDR_LENGTH-1:0] dm_addr;
    logic                      im_we;
    logic [IM_ADDR_LENGTH-1:0] im_addr;
    logic [INST_WIDTH-1:0]     im_data;
    logic                      cpu_enable;
    logic                      cpu_reset;
    logic                      busy;

    modport master (
        input  rx_data, rx_done, tx_done, halt_flag, pc_value, rf_data, dm_data,
        output tx_data, tx_start, rf_addr, dm_addr, im_we, im_addr, im_data,
               cpu_enable, cpu_reset, busy
    );

    modport slave (
        output rx_data, rx_done, tx_done, halt_flag, pc_value, rf_data, dm_data,
        input  tx_data, tx_start, rf_addr, dm_addr, im_we, im_addr, im_data,
               cpu_enable, cpu_reset, busy
    );
endinterface

// File: rtl/debug_sequencer.sv
// UART-driven debug sequencer: loads instruction memory, runs or single-steps the
// core, and dumps PC, register file and data memory back over the transmitter.
module debug_sequencer #(
    parameter int UART_WIDTH     = 8,
    parameter int INST_WIDTH     = 32,
    parameter int IM_ADDR_LENGTH = 32,
    parameter int IM_DEPTH       = 256,
    parameter int RF_DEPTH       = 32,
    parameter int DM_ADDR_LENGTH = 32,
    parameter int DM_DEPTH       = 32
) (
    input  logic              clk,
    input  logic              reset,
    debug_sequencer_if.master bus
);
    localparam int CHARS    = INST_WIDTH / UART_WIDTH;
    localparam int WORDS    = 1 + RF_DEPTH + DM_DEPTH;
    localparam int CHAR_W   = $clog2(CHARS) + 1;
    localparam int IM_IDX_W = $clog2(IM_DEPTH) + 1;
    localparam int WORD_W   = $clog2(WORDS) + 1;

    localparam logic [UART_WIDTH-1:0] CMD_LOAD = UART_WIDTH'('h4C);
    localparam logic [UART_WIDTH-1:0] CMD_CONT = UART_WIDTH'('h43);
    localparam logic [UART_WIDTH-1:0] CMD_STEP = UART_WIDTH'('h53);
    localparam logic [UART_WIDTH-1:0] CMD_NEXT = UART_WIDTH'('h4E);
    localparam logic [UART_WIDTH-1:0] CMD_EXIT = UART_WIDTH'('h45);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_BYTE, S_LOAD_WRITE, S_RUN,
        S_STEP_WAIT, S_STEP_EXEC, S_DUMP_SEND, S_DUMP_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [INST_WIDTH-1:0] r_asm;
    logic [CHAR_W-1:0]     r_byte_cnt;
    logic [IM_IDX_W-1:0]   r_im_idx;
    logic [INST_WIDTH-1:0] r_shift;
    logic [CHAR_W-1:0]     r_char_cnt;
    logic [WORD_W-1:0]     r_word_idx;
    logic                  r_step_mode;
    logic                  r_halt_seen;
    logic                  r_cpu_reset;

    logic                  w_rx;
    logic                  w_byte_last;
    logic                  w_char_last;
    logic                  w_dump_done;
    logic                  w_halted;
    logic                  w_in_dump;
    logic                  w_load_word;
    logic                  w_rf_sel;
    logic                  w_dm_sel;
    logic [INST_WIDTH-1:0] w_dump_word;

    // A transmitter completion always wins; a coincident received byte is dropped.
    assign w_rx        = bus.rx_done && !bus.tx_done;
    assign w_byte_last = (r_byte_cnt == CHAR_W'(CHARS - 1));
    assign w_char_last = (r_char_cnt == CHAR_W'(CHARS - 1));
    assign w_dump_done = (r_word_idx == WORD_W'(WORDS));
    assign w_halted    = r_halt_seen || bus.halt_flag;
    assign w_in_dump   = (r_state == S_DUMP_SEND) || (r_state == S_DUMP_WAIT);

    // r_word_idx names the next word to capture, so the read addresses settle
    // while the previous word is still being transmitted.
    assign w_rf_sel    = (r_word_idx != '0) && (r_word_idx <= WORD_W'(RF_DEPTH));
    assign w_dm_sel    = (r_word_idx > WORD_W'(RF_DEPTH)) && (r_word_idx < WORD_W'(WORDS));
    assign w_dump_word = w_rf_sel ? bus.rf_data : (w_dm_sel ? bus.dm_data : bus.pc_value);
    assign w_load_word = ((r_state == S_RUN) && bus.halt_flag) || (r_state == S_STEP_EXEC) ||
                         ((r_state == S_DUMP_WAIT) && bus.tx_done && w_char_last && !w_dump_done);

    // NOTE: next state gets its default before the case so no path infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_rx) begin
                    if (bus.rx_data == CMD_LOAD)      w_next = S_LOAD_BYTE;
                    else if (bus.rx_data == CMD_CONT) w_next = S_RUN;
                    else if (bus.rx_data == CMD_STEP) w_next = S_STEP_WAIT;
                end
            end
            S_LOAD_BYTE:  if (w_rx && w_byte_last) w_next = S_LOAD_WRITE;
            S_LOAD_WRITE: w_next = ((&r_asm) || (r_im_idx == IM_IDX_W'(IM_DEPTH - 1))) ? S_IDLE : S_LOAD_BYTE;
            S_RUN:        if (bus.halt_flag) w_next = S_DUMP_SEND;
            S_STEP_WAIT: begin
                if (w_rx) begin
                    if (bus.rx_data == CMD_NEXT)      w_next = S_STEP_EXEC;
                    else if (bus.rx_data == CMD_EXIT) w_next = S_IDLE;
                end
            end
            S_STEP_EXEC:  w_next = S_DUMP_SEND;
            S_DUMP_SEND:  w_next = S_DUMP_WAIT;
            S_DUMP_WAIT: begin
                if (bus.tx_done) begin
                    if (w_char_last && w_dump_done) w_next = (r_step_mode && !w_halted) ? S_STEP_WAIT : S_IDLE;
                    else                            w_next = S_DUMP_SEND;
                end
            end
            default:      w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_asm       <= '0;
            r_byte_cnt  <= '0;
            r_im_idx    <= '0;
            r_shift     <= '0;
            r_char_cnt  <= '0;
            r_word_idx  <= '0;
            r_step_mode <= 1'b0;
            r_halt_seen <= 1'b0;
            r_cpu_reset <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cpu_reset <= 1'b0;
            if ((r_state == S_IDLE) && w_rx) begin
                r_step_mode <= (bus.rx_data == CMD_STEP);
                if (bus.rx_data == CMD_LOAD) begin
                    r_cpu_reset <= 1'b1;
                    r_im_idx    <= '0;
                    r_asm       <= '0;
                    r_byte_cnt  <= '0;
                end
            end
            if ((r_state == S_LOAD_BYTE) && w_rx) begin
                r_asm      <= (r_asm << UART_WIDTH) | INST_WIDTH'(bus.rx_data);
                r_byte_cnt <= w_byte_last ? '0 : r_byte_cnt + CHAR_W'(1);
            end
            if (r_state == S_LOAD_WRITE) r_im_idx <= r_im_idx + IM_IDX_W'(1);
            if (r_state == S_STEP_EXEC)             r_halt_seen <= bus.halt_flag;
            else if (w_in_dump && bus.halt_flag)    r_halt_seen <= 1'b1;
            if (w_load_word) begin
                r_shift    <= w_dump_word;
                r_word_idx <= r_word_idx + WORD_W'(1);
                r_char_cnt <= '0;
            end else if ((r_state == S_DUMP_WAIT) && bus.tx_done) begin
                if (w_char_last) begin
                    r_shift    <= '0;
                    r_word_idx <= '0;
                    r_char_cnt <= '0;
                end else begin
                    r_shift    <= r_shift << UART_WIDTH;
                    r_char_cnt <= r_char_cnt + CHAR_W'(1);
                end
            end
        end
    end

    assign bus.tx_start   = (r_state == S_DUMP_SEND);
    assign bus.tx_data    = r_shift[INST_WIDTH-1 -: UART_WIDTH];
    assign bus.im_we      = (r_state == S_LOAD_WRITE);
    assign bus.im_addr    = IM_ADDR_LENGTH'(r_im_idx);
    assign bus.im_data    = r_asm;
    assign bus.cpu_enable = ((r_state == S_RUN) && !bus.halt_flag) || (r_state == S_STEP_EXEC);
    assign bus.cpu_reset  = r_cpu_reset;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rf_addr    = w_rf_sel ? 5'(r_word_idx - WORD_W'(1)) : 5'd0;
    assign bus.dm_addr    = w_dm_sel ? DM_ADDR_LENGTH'(r_word_idx - WORD_W'(RF_DEPTH + 1)) : '0;
endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Parametrised successor to the pipeline debug controller; sits between the UART (rx/tx) and the processor core.
- Assembles byte-wide UART traffic into instruction words and loads instruction memory.
- Runs the core in continuous or single-step mode, dumping PC, register file and data memory back over UART.
- Generalises word/byte widths and memory depths, and adds step mode and the tx dump path.

Parameters:
UART_WIDTH, 8, UART character width in bits
INST_WIDTH, 32, instruction/data word width; must be a multiple of UART_WIDTH
IM_ADDR_LENGTH, 32, instruction memory address width (word index)
IM_DEPTH, 256, max instructions loadable
RF_DEPTH, 32, registers dumped
DM_ADDR_LENGTH, 32, data memory address width (word index)
DM_DEPTH, 32, data memory words dumped

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
rx_data  in  UART_WIDTH  received character
rx_done  in  1  one-cycle strobe, rx_data valid
tx_done  in  1  one-cycle strobe, transmitter finished current character
tx_data  out  UART_WIDTH  character to send
tx_start  out  1  one-cycle strobe, send tx_data
halt_flag  in  1  core retired HALT
pc_value  in  INST_WIDTH  current PC
rf_data  in  INST_WIDTH  register read data (combinational from rf_addr)
dm_data  in  INST_WIDTH  data memory read data (combinational from dm_addr)
rf_addr  out  5  register read address
dm_addr  out  DM_ADDR_LENGTH  data memory debug read address
im_we  out  1  instruction memory write enable
im_addr  out  IM_ADDR_LENGTH  instruction memory write address
im_data  out  INST_WIDTH  instruction memory write data
cpu_enable  out  1  core clock enable
cpu_reset  out  1  synchronous reset pulse to core
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, byte/word counters 0.
- Commands are only recognised in IDLE:
  - 0x4C 'L' = load
  - 0x43 'C' = continuous
  - 0x53 'S` = step
  - Any other byte is ignored; stay in IDLE.
- 'L':
  - cpu_reset high for exactly 1 cycle; im_addr cleared to 0.
  - Enter LOAD_BYTE. Each rx_done shifts rx_data into an assembly register, MSB-first.
  - After INST_WIDTH/UART_WIDTH bytes: LOAD_WRITE drives im_we=1 for exactly 1 cycle with im_data=word, im_addr=index; index increments the cycle after.
  - If the word is all-ones (HALT) or index reaches IM_DEPTH-1: return to IDLE after the write; otherwise back to LOAD_BYTE.
  - Partial words are held indefinitely (no timeout).
- 'C': RUN.
  - cpu_enable=1 each cycle until halt_flag is sampled high.
  - On that edge cpu_enable drops to 0 in the same cycle halt_flag is seen (combinational gate), then DUMP.
- 'S': STEP_WAIT, cpu_enable=0.
  - 0x4E 'N': STEP_EXEC asserts cpu_enable for exactly 1 cycle, then DUMP, then return to STEP_WAIT.
  - 0x45 'E': go to IDLE.
  - Other bytes ignored.
  - If halt_flag is high after a step, the dump completes and the block goes to IDLE.
- DUMP order, each word sent MSB-first as INST_WIDTH/UART_WIDTH characters:
  - pc_value
  - rf_addr 0..RF_DEPTH-1
  - dm_addr 0..DM_DEPTH-1
- Per character: DUMP_SEND asserts tx_start for 1 cycle with tx_data stable; DUMP_WAIT holds tx_data until tx_done; next character 1 cycle later.
- Address/word is sampled when entering the first character of each word.
- rx_done during RUN/DUMP/STEP_EXEC is ignored and not queued.
- rx_done and tx_done on the same cycle: tx_done is processed, rx_done is dropped.
- Asynchronous reset mid-operation aborts immediately to IDLE with all outputs 0. A partially loaded instruction memory is left as-is.
- Counters are sized ceil(log2(depth))+1 bits; no wrap beyond depth.

Test Plan:
- Load: bytes 4C, 00 00 00 2D, FF FF FF FF at 1 rx_done per 10 cycles.
  - Required: im_we pulses twice, (addr0, 0x0000002D) then (addr1, 0xFFFFFFFF).
  - Required: busy falls; cpu_reset pulsed once.
- Continuous: 'C', halt_flag raised 20 cycles later.
  - Required: cpu_enable high exactly 20 cycles.
  - Required: 4*(1+32+32)=260 tx_start pulses, each only after the prior tx_done.
  - Required: first 4 chars equal pc_value bytes MSB-first.
- Step: 'S','N','N','E'.
  - Required: two 1-cycle cpu_enable pulses, each followed by a 260-char dump; IDLE after 'E'.
- Unknown/overlap: 0x7A in IDLE -> no state change.
  - rx_done during RUN -> no im_we, no effect.
  - Simultaneous rx_done/tx_done in DUMP -> dump continues correctly.
- Reset mid-load: assert reset after 2 bytes of a word.
  - Required: outputs 0 immediately.
  - Required: a new 'L' starts at im_addr 0 with a clean assembly register.
- Depth limit, IM_DEPTH=4: send 6 non-HALT words.
  - Required: only 4 im_we pulses, then IDLE; remaining bytes treated as commands and ignored.
